// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline inter-stage registers.
//   stage_state_e : occupancy of a stage (EMPTY / ONE / FULL)
//   NOP_INSTR     : instruction word used as a bubble
//   *_DW          : default payload widths of the four CPU stage registers
//   state_holds   : helper, true when a stage holds at least one valid entry
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // main_v=0
        ST_ONE   = 2'd1,  // main_v=1, skid_v=0
        ST_FULL  = 2'd2   // main_v=1, skid_v=1
    } stage_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    localparam int IF_ID_DW  = 64;   // {instr, pc_plus4}
    localparam int ID_EX_DW  = 160;
    localparam int EX_MEM_DW = 112;
    localparam int MEM_WB_DW = 72;

    function automatic logic state_holds(stage_state_e s);
        return (s != ST_EMPTY);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Ready/valid stream between pipeline stages.
//   valid : producer has a payload this cycle
//   data  : payload (DW bits)
//   ready : consumer can take it this cycle
// A transfer happens on a rising edge where valid and ready are both 1.
// The producer may not make valid depend on ready.
//   master : producer side (drives valid/data)
//   slave  : consumer side (drives ready)
interface pipe_stage_reg_if #(
    parameter int DW = 64
);
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage performance counters.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (clears count)
//   inc     : count one event this cycle
//   count   : current value, sticks at all-ones
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] ONE = 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage register for the pipelined CPU with ready/valid flow control.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : drop everything held (and anything offered) this cycle
//   stall        : freeze the stage; no handshake completes on either side
//   up (slave)   : upstream stream, up.ready is the stage's in_ready
//   dn (master)  : downstream stream, dn.data is the main register
//   stall_cnt    : cycles a valid entry sat here without being taken
//   flush_cnt    : flushes that killed at least one valid entry
//   state        : current occupancy (EMPTY/ONE/FULL)
// SKID=1 adds a second entry so in_ready depends only on registered state.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int            DW        = 64,
    parameter logic [DW-1:0] RESET_VAL = '0,
    parameter bit            SKID      = 1'b1,
    parameter int            CW        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               stall,
    pipe_stage_reg_if.slave    up,
    pipe_stage_reg_if.master   dn,
    output logic [CW-1:0]      stall_cnt,
    output logic [CW-1:0]      flush_cnt,
    output stage_state_e       state
);
    stage_state_e  state_q, state_d;
    logic [DW-1:0] main_d, skid_d;
    logic          main_v, skid_v;
    logic          in_fire, out_fire;
    logic          load_main_in, load_main_skid, load_skid;

    assign main_v = state_holds(state_q);
    assign skid_v = (state_q == ST_FULL);

    assign dn.valid = main_v & ~stall;
    assign dn.data  = main_d;
    assign state    = state_q;

    generate
        if (SKID) begin : g_skid
            // Registered-only ready: no combinational path from dn.ready.
            assign up.ready = ~skid_v & ~stall;
        end else begin : g_single
            assign up.ready = (~main_v | dn.ready) & ~stall;
        end
    endgenerate

    assign in_fire  = up.valid & up.ready;
    assign out_fire = dn.valid & dn.ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Fires seen during a flush cycle are discarded.
            state_d = ST_EMPTY;
        end else if (!stall) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        // Only reachable with the skid entry present.
                        if (SKID) begin
                            state_d   = ST_FULL;
                            load_skid = 1'b1;
                        end
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            main_d  <= RESET_VAL;
            skid_d  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            if (flush) begin
                main_d <= RESET_VAL;
                skid_d <= RESET_VAL;
            end else begin
                if (load_main_in) begin
                    main_d <= up.data;
                end else if (load_main_skid) begin
                    main_d <= skid_d;
                end
                if (load_skid) begin
                    skid_d <= up.data;
                end
            end
        end
    end

    sat_counter #(.CW(CW)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (main_v & ~flush & (stall | ~dn.ready)),
        .count   (stall_cnt)
    );

    sat_counter #(.CW(CW)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush & (main_v | skid_v)),
        .count   (flush_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances share one stimulus stream
//   dut 0 : SKID=1, CW=16
//   dut 1 : SKID=0, CW=16
//   dut 2 : SKID=1, CW=4 (counter saturation)
// Each instance has its own queue-level reference model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 64;
    localparam int ND = 3;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          stall;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg_if #(.DW(DW)) up0 ();
    pipe_stage_reg_if #(.DW(DW)) dn0 ();
    pipe_stage_reg_if #(.DW(DW)) up1 ();
    pipe_stage_reg_if #(.DW(DW)) dn1 ();
    pipe_stage_reg_if #(.DW(DW)) up2 ();
    pipe_stage_reg_if #(.DW(DW)) dn2 ();

    logic [15:0]  sc0, fc0, sc1, fc1;
    logic [3:0]   sc2, fc2;
    stage_state_e st0, st1, st2;

    assign up0.valid = in_valid;
    assign up0.data  = in_data;
    assign dn0.ready = out_ready;
    assign up1.valid = in_valid;
    assign up1.data  = in_data;
    assign dn1.ready = out_ready;
    assign up2.valid = in_valid;
    assign up2.data  = in_data;
    assign dn2.ready = out_ready;

    pipe_stage_reg #(.DW(DW), .RESET_VAL('0), .SKID(1'b1), .CW(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
        .up(up0.slave), .dn(dn0.master),
        .stall_cnt(sc0), .flush_cnt(fc0), .state(st0)
    );
    pipe_stage_reg #(.DW(DW), .RESET_VAL('0), .SKID(1'b0), .CW(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
        .up(up1.slave), .dn(dn1.master),
        .stall_cnt(sc1), .flush_cnt(fc1), .state(st1)
    );
    pipe_stage_reg #(.DW(DW), .RESET_VAL('0), .SKID(1'b1), .CW(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
        .up(up2.slave), .dn(dn2.master),
        .stall_cnt(sc2), .flush_cnt(fc2), .state(st2)
    );

    // Observed outputs gathered per instance.
    logic          o_ready [ND];
    logic          o_valid [ND];
    logic [DW-1:0] o_data  [ND];
    logic [15:0]   o_sc    [ND];
    logic [15:0]   o_fc    [ND];
    stage_state_e  o_st    [ND];

    assign o_ready[0] = up0.ready;  assign o_valid[0] = dn0.valid;  assign o_data[0] = dn0.data;
    assign o_ready[1] = up1.ready;  assign o_valid[1] = dn1.valid;  assign o_data[1] = dn1.data;
    assign o_ready[2] = up2.ready;  assign o_valid[2] = dn2.valid;  assign o_data[2] = dn2.data;
    assign o_sc[0] = sc0;  assign o_fc[0] = fc0;  assign o_st[0] = st0;
    assign o_sc[1] = sc1;  assign o_fc[1] = fc1;  assign o_st[1] = st1;
    assign o_sc[2] = {12'd0, sc2};  assign o_fc[2] = {12'd0, fc2};  assign o_st[2] = st2;

    // Reference model: a FIFO of up to cap entries plus the last payload shown.
    int            cap  [ND] = '{2, 1, 2};
    int            smax [ND] = '{65535, 65535, 15};
    int            cnt  [ND];
    logic [DW-1:0] mq   [ND][2];
    logic [DW-1:0] last [ND];
    int            msc  [ND];
    int            mfc  [ND];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int m, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d got=%h exp=%h", tag, m, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < ND; m++) begin
            cnt[m]  = 0;
            last[m] = '0;
            msc[m]  = 0;
            mfc[m]  = 0;
        end
    endtask

    // One clock cycle: drive at negedge, check, advance model on posedge.
    task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy,
                         input logic st, input logic fl);
        logic er, ev;
        logic in_f  [ND];
        logic out_f [ND];
        stage_state_e es;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        #1;
        for (int m = 0; m < ND; m++) begin
            er = ((cap[m] == 2) ? (cnt[m] < 2) : ((cnt[m] == 0) || ordy)) && !st;
            ev = (cnt[m] > 0) && !st;
            es = (cnt[m] == 0) ? ST_EMPTY : ((cnt[m] == 1) ? ST_ONE : ST_FULL);
            chk("in_ready",  m, {63'd0, o_ready[m]}, {63'd0, er});
            chk("out_valid", m, {63'd0, o_valid[m]}, {63'd0, ev});
            chk("out_data",  m, o_data[m], (cnt[m] > 0) ? mq[m][0] : last[m]);
            chk("stall_cnt", m, {48'd0, o_sc[m]}, DW'(msc[m]));
            chk("flush_cnt", m, {48'd0, o_fc[m]}, DW'(mfc[m]));
            chk("state",     m, {62'd0, o_st[m]}, {62'd0, es});
            in_f[m]  = er & iv;
            out_f[m] = ev & ordy;
        end
        @(posedge clk);
        for (int m = 0; m < ND; m++) begin
            if (cnt[m] > 0 && !fl && (st || !ordy) && msc[m] < smax[m]) msc[m]++;
            if (fl && cnt[m] > 0 && mfc[m] < smax[m]) mfc[m]++;
            if (fl) begin
                cnt[m]  = 0;
                last[m] = '0;
            end else begin
                if (out_f[m]) begin
                    last[m]  = mq[m][0];
                    mq[m][0] = mq[m][1];
                    cnt[m]--;
                end
                if (in_f[m]) begin
                    mq[m][cnt[m]] = id;
                    cnt[m]++;
                end
            end
        end
        @(negedge clk);
    endtask

    // Async reset checks, taken before any clock edge sees the reset.
    task automatic reset_check();
        for (int m = 0; m < ND; m++) begin
            chk("rst_in_ready",  m, {63'd0, o_ready[m]}, 64'd1);
            chk("rst_out_valid", m, {63'd0, o_valid[m]}, 64'd0);
            chk("rst_out_data",  m, o_data[m], 64'd0);
            chk("rst_stall_cnt", m, {48'd0, o_sc[m]}, 64'd0);
            chk("rst_flush_cnt", m, {48'd0, o_fc[m]}, 64'd0);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #2;
        reset_check();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back throughput.
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: fill, then drain in order.
        cycle(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush while full with a new word offered, then flush while empty.
        cycle(1'b1, 64'h1111, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h2222, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stall for three cycles with both sides willing.
        cycle(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'h66, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Long stall: the 4-bit counter must stick at 15.
        cycle(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("sat_stall_cnt", 2, {48'd0, o_sc[2]}, 64'd15);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a full stage.
        cycle(1'b1, 64'h8888, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h9999, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_full", 0, {62'd0, o_st[0]}, {62'd0, ST_FULL});
        #1;
        reset_n = 1'b0;
        #1;
        reset_check();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        in_valid = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), {$urandom, $urandom},
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
